mac_dot_seq: RTL and testbench
==============================

Name: mac_dot_seq

Overview:
- Parametrised successor to the fixed 3x8-bit serial multiply-accumulate unit. Computes the dot product of packed attribute and coefficient vectors, one element per clock.
- Optionally accumulates across several input beats, which allows dot products longer than one beat. Operands can be signed or unsigned; the accumulator can saturate or wrap.
- Sits between the attribute/coefficient RAM readers and the BDD node-compare logic. Valid/ready handshakes are used on both sides.

Parameters:
- ELEM_W, 8: width of one element.
- NUM_ELEM, 3: elements per beat.
- ACC_W, 20: accumulator/result width. Must satisfy ACC_W >= 2*ELEM_W (elaboration-time check).
- SIGNED, 0: 1 = two's-complement operands and accumulator; 0 = unsigned.
- SATURATE, 1: 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_in  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_attr  in  NUM_ELEM*ELEM_W  packed attributes; element 0 = most-significant ELEM_W bits.
- in_coeff  in  NUM_ELEM*ELEM_W  packed coefficients; same packing as in_attr.
- in_last  in  1  this beat ends the dot product.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_acc  out  ACC_W  dot-product result.
- out_ovf  out  1  overflow occurred at least once during this result (sticky per result).

Behaviour:
- Reset: one clock edge with rst_in=1 does all of the following.
  - state=IDLE; accumulator=0; ovf=0; element index=0.
  - out_valid=0, out_acc=0, out_ovf=0, in_ready=1 (from the next cycle).
  - Reset has priority over every other event, including mid-MAC and DONE. A partial sum or pending result is discarded.
- States: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_attr, in_coeff and in_last into holding registers; idx=0; go to MAC.
  - The accumulator is NOT cleared here, so partial sums carry over between beats.
- MAC:
  - in_ready=0.
  - Each cycle: prod = attr[idx]*coeff[idx], full 2*ELEM_W width.
  - prod is sign-extended (SIGNED=1) or zero-extended to ACC_W+1 bits and added to the accumulator.
  - idx runs 0..NUM_ELEM-1, so exactly NUM_ELEM cycles are spent in MAC.
  - After the idx=NUM_ELEM-1 edge:
    - held last=1: go to DONE.
    - held last=0: go to IDLE.
- Overflow detection:
  - Unsigned: carry out of bit ACC_W-1.
  - Signed: the two operands have the same sign and the result sign differs.
- On overflow:
  - ovf is set sticky.
  - SATURATE=1: the accumulator is clamped, to 2^ACC_W-1 (unsigned) or to 2^(ACC_W-1)-1 / -2^(ACC_W-1) (signed, matching the direction of overflow). Subsequent adds continue from the clamped value.
  - SATURATE=0: the sum wraps.
- DONE:
  - out_valid=1; out_acc and out_ovf are registered and stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: accumulator=0, ovf=0; go to IDLE.
  - in_ready rises in the next cycle.
- Latency:
  - Single-beat product: out_valid asserts NUM_ELEM cycles after the accepting edge.
  - Throughput: one beat per NUM_ELEM+1 cycles; a result adds one extra cycle minimum for DONE.
- out_acc holds its last value outside DONE. It is not cleared on handshake.
- Inputs are ignored outside IDLE. in_valid held high while in_ready=0 is legal and is not captured.
- A zero-element product does not exist (NUM_ELEM >= 1 is enforced).

Decomposition:
- Package mac_dot_pkg holds:
  - the state enum (IDLE, MAC, DONE);
  - function sat_limits(ACC_W, SIGNED) returning the max/min constants;
  - the localparam PROD_W = 2*ELEM_W.
- One sub-module: mac_sat_add.
  - Combinational ACC_W adder with ext-product input.
  - Parameterised by SIGNED and SATURATE.
  - Outputs sum and ovf.
  - The FSM, operand registers and element mux stay in the top level.

Test Plan (all cases use ELEM_W=8, NUM_ELEM=3, ACC_W=20 unless stated):
- Basic: attr=0x010203, coeff=0x040506, last=1 -> out_valid 3 cycles after the accept edge; out_acc=32 (0x00020); out_ovf=0.
- Multi-beat: beat1 attr=0x010203/coeff=0x040506 with last=0, then beat2 with the same data and last=1 -> single result out_acc=64; no out_valid after beat1.
- Saturation: 6 beats of 0xFFFFFF x 0xFFFFFF, last on the 6th (true sum 1170450) -> SATURATE=1: out_acc=0xFFFFF, out_ovf=1. SATURATE=0: out_acc=1170450-1048576=121874, out_ovf=1.
- Signed: SIGNED=1, attr=0xFF0201, coeff=0x030405, last=1 -> out_acc=10 (-3+8+5). Second case attr=0xFF0000, coeff=0x7F0000 -> out_acc=0xFFF81 (-127).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_acc and out_ovf stay stable and in_ready=0; on the out_ready=1 edge, in_ready=1 in the next cycle; the next result starts from 0.
- Reset mid-operation: assert rst_in in the second MAC cycle of a last=0 beat -> next cycle in_ready=1, out_valid=0; a following single beat 0x010203/0x040506 yields exactly 32.

Source files
------------

// File: rtl/mac_dot_pkg.sv
// Shared types and constants for the serial dot-product MAC.
// Saturation limits are returned 64 bits wide; callers keep the low ACC_W bits.
package mac_dot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DONE
  } mac_state_e;

  localparam int DFLT_ELEM_W = 8;
  localparam int PROD_W      = 2 * DFLT_ELEM_W;

  typedef struct packed {
    logic [63:0] max_v;
    logic [63:0] min_v;
  } sat_lim_t;

  function automatic sat_lim_t sat_limits(input int acc_w, input bit is_signed);
    sat_lim_t l;
    if (is_signed) begin
      l.max_v = (64'd1 << (acc_w - 1)) - 64'd1;
      l.min_v = ~64'd0 << (acc_w - 1);
    end else begin
      l.max_v = (64'd1 << acc_w) - 64'd1;
      l.min_v = '0;
    end
    return l;
  endfunction

  function automatic int prod_w(input int elem_w);
    return 2 * elem_w;
  endfunction

endpackage

// File: rtl/mac_dot_seq_if.sv
// Valid/ready operand input and result output of the dot-product MAC.
// The master drives operands and out_ready; the slave is the MAC itself.
interface mac_dot_seq_if #(
  parameter int ELEM_W   = 8,
  parameter int NUM_ELEM = 3,
  parameter int ACC_W    = 20
);
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_ELEM*ELEM_W-1:0]   in_attr;
  logic [NUM_ELEM*ELEM_W-1:0]   in_coeff;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic [ACC_W-1:0]             out_acc;
  logic                         out_ovf;

  modport master (
    output in_valid, in_attr, in_coeff, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_attr, in_coeff, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/mac_sat_add.sv
// Accumulator adder: adds an (ACC_W+1)-bit extended product to the accumulator,
// flags overflow and optionally clamps to the representable range.
module mac_sat_add
  import mac_dot_pkg::*;
#(
  parameter int ACC_W    = 20,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W:0]   i_prod_ext,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  localparam sat_lim_t         LIM   = sat_limits(ACC_W, SIGNED != 0);
  localparam logic [ACC_W-1:0] MAX_V = LIM.max_v[ACC_W-1:0];
  localparam logic [ACC_W-1:0] MIN_V = LIM.min_v[ACC_W-1:0];

  logic [ACC_W:0] w_acc_ext;
  logic [ACC_W:0] w_raw;
  logic           w_ovf;

  // One guard bit: for signed it holds the true sign, for unsigned the carry.
  always_comb begin
    w_acc_ext = (SIGNED != 0) ? {i_acc[ACC_W-1], i_acc} : {1'b0, i_acc};
    w_raw     = w_acc_ext + i_prod_ext;
    w_ovf     = (SIGNED != 0) ? (w_raw[ACC_W] ^ w_raw[ACC_W-1]) : w_raw[ACC_W];
    o_sum     = w_raw[ACC_W-1:0];
    if (w_ovf && (SATURATE != 0)) begin
      o_sum = ((SIGNED != 0) && w_raw[ACC_W]) ? MIN_V : MAX_V;
    end
    o_ovf = w_ovf;
  end

endmodule

// File: rtl/mac_dot_seq.sv
// Serial dot-product MAC: one element product per clock, accumulating across
// beats until a beat flagged last, then presents the result on a valid/ready port.
//
// state   | meaning
// IDLE    | waiting for an input beat, in_ready high
// MAC     | adding one element product per cycle
// DONE    | result held on out_acc/out_ovf until out_ready
module mac_dot_seq
  import mac_dot_pkg::*;
#(
  parameter int ELEM_W   = 8,
  parameter int NUM_ELEM = 3,
  parameter int ACC_W    = 20,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic            clk,
  input  logic            rst_in,
  mac_dot_seq_if.slave    bus
);

  localparam int               PW       = prod_w(ELEM_W);
  localparam int               IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  if (ACC_W < 2 * ELEM_W) begin : g_bad_acc_w
    $error("mac_dot_seq: ACC_W must be at least 2*ELEM_W");
  end
  if (ACC_W > 63) begin : g_bad_acc_max
    $error("mac_dot_seq: ACC_W above 63 is not supported");
  end
  if (NUM_ELEM < 1) begin : g_bad_num_elem
    $error("mac_dot_seq: NUM_ELEM must be at least 1");
  end

  mac_state_e                  r_state;
  logic [NUM_ELEM*ELEM_W-1:0]  r_attr;
  logic [NUM_ELEM*ELEM_W-1:0]  r_coeff;
  logic                        r_last;
  logic [IDX_W-1:0]            r_idx;
  logic [ACC_W-1:0]            r_acc;
  logic                        r_ovf;
  logic                        r_in_ready;
  logic                        r_out_valid;
  logic [ACC_W-1:0]            r_out_acc;
  logic                        r_out_ovf;

  logic [ELEM_W-1:0]           w_a;
  logic [ELEM_W-1:0]           w_b;
  logic [PW-1:0]               w_prod;
  logic [ACC_W:0]              w_prod_ext;
  logic [ACC_W-1:0]            w_sum;
  logic                        w_ovf;

  // Element 0 sits in the most-significant slice of the packed vectors.
  always_comb begin
    w_a = r_attr[(NUM_ELEM - 1 - int'(r_idx)) * ELEM_W +: ELEM_W];
    w_b = r_coeff[(NUM_ELEM - 1 - int'(r_idx)) * ELEM_W +: ELEM_W];
    if (SIGNED != 0) begin
      w_prod = $signed({{ELEM_W{w_a[ELEM_W-1]}}, w_a}) * $signed({{ELEM_W{w_b[ELEM_W-1]}}, w_b});
      w_prod_ext = {{(ACC_W + 1 - PW){w_prod[PW-1]}}, w_prod};
    end else begin
      w_prod = {{ELEM_W{1'b0}}, w_a} * {{ELEM_W{1'b0}}, w_b};
      w_prod_ext = {{(ACC_W + 1 - PW){1'b0}}, w_prod};
    end
  end

  mac_sat_add #(
    .ACC_W    (ACC_W),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_add (
    .i_acc      (r_acc),
    .i_prod_ext (w_prod_ext),
    .o_sum      (w_sum),
    .o_ovf      (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_attr      <= '0;
      r_coeff     <= '0;
      r_last      <= 1'b0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Accumulator deliberately kept so partial sums span beats.
          if (bus.in_valid && r_in_ready) begin
            r_attr     <= bus.in_attr;
            r_coeff    <= bus.in_coeff;
            r_last     <= bus.in_last;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= w_sum;
          r_ovf <= r_ovf | w_ovf;
          if (r_idx == LAST_IDX) begin
            r_idx <= '0;
            if (r_last) begin
              r_out_valid <= 1'b1;
              r_out_acc   <= w_sum;
              r_out_ovf   <= r_ovf | w_ovf;
              r_state     <= ST_DONE;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_acc   = r_out_acc;
  assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: four instances (unsigned/signed x saturate/wrap) share
// one stimulus stream and are compared with an integer-arithmetic reference.
module tb_mac_dot_seq;

  localparam int EW = 8;
  localparam int NE = 3;
  localparam int AW = 20;
  localparam int ND = 4;

  logic             clk = 1'b0;
  logic             rst_in = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;
  logic [NE*EW-1:0] in_attr = '0;
  logic [NE*EW-1:0] in_coeff = '0;

  logic [AW-1:0]    obs_acc   [ND];
  logic             obs_ovf   [ND];
  logic             obs_valid [ND];
  logic             obs_ready [ND];

  always #5 clk = ~clk;

  // Instance k: SIGNED = k/2, SATURATE = 1 - k%2
  for (genvar k = 0; k < ND; k++) begin : g_dut
    mac_dot_seq_if #(.ELEM_W(EW), .NUM_ELEM(NE), .ACC_W(AW)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in_attr   = in_attr;
    assign bus.in_coeff  = in_coeff;
    assign bus.in_last   = in_last;
    assign bus.out_ready = out_ready;
    assign obs_acc[k]    = bus.out_acc;
    assign obs_ovf[k]    = bus.out_ovf;
    assign obs_valid[k]  = bus.out_valid;
    assign obs_ready[k]  = bus.in_ready;
    mac_dot_seq #(
      .ELEM_W   (EW),
      .NUM_ELEM (NE),
      .ACC_W    (AW),
      .SIGNED   (k / 2),
      .SATURATE (1 - (k % 2))
    ) u_dut (
      .clk    (clk),
      .rst_in (rst_in),
      .bus    (bus)
    );
  end

  int     n_assert = 0;
  int     n_fail = 0;
  longint m_acc [ND];
  bit     m_ovf [ND];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < ND; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  // True mathematical sum, then range check against the configuration.
  task automatic model_beat(input logic [NE*EW-1:0] a, input logic [NE*EW-1:0] c);
    for (int k = 0; k < ND; k++) begin
      for (int e = 0; e < NE; e++) begin
        logic [EW-1:0] ea;
        logic [EW-1:0] ec;
        longint pa, pb, s, hi, lo;
        bit sgn, sat;
        sgn = (k >= 2);
        sat = (k % 2 == 0);
        ea = a[(NE - 1 - e) * EW +: EW];
        ec = c[(NE - 1 - e) * EW +: EW];
        pa = longint'(ea);
        pb = longint'(ec);
        if (sgn && ea[EW-1]) pa -= (longint'(1) << EW);
        if (sgn && ec[EW-1]) pb -= (longint'(1) << EW);
        hi = sgn ? (longint'(1) << (AW - 1)) - 1 : (longint'(1) << AW) - 1;
        lo = sgn ? -(longint'(1) << (AW - 1)) : 0;
        s = m_acc[k] + pa * pb;
        if (s > hi) begin
          m_ovf[k] = 1'b1;
          s = sat ? hi : s - (longint'(1) << AW);
        end else if (s < lo) begin
          m_ovf[k] = 1'b1;
          s = sat ? lo : s + (longint'(1) << AW);
        end
        m_acc[k] = s;
      end
    end
  endtask

  function automatic logic [AW-1:0] exp_acc(input int k);
    logic [63:0] v;
    v = 64'(m_acc[k]);
    return v[AW-1:0];
  endfunction

  // Entered and left at a falling edge; on return with last=1 the result is up.
  task automatic send_beat(input logic [NE*EW-1:0] a, input logic [NE*EW-1:0] c, input logic last);
    int guard;
    guard = 0;
    while (obs_ready[0] !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("ready_timeout", {31'd0, obs_ready[0]}, 32'd1);
    in_valid = 1'b1;
    in_attr  = a;
    in_coeff = c;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    model_beat(a, c);
    for (int i = 0; i < NE; i++) begin
      check($sformatf("mac_busy_ready_c%0d", i), {31'd0, obs_ready[0]}, 32'd0);
      check($sformatf("mac_busy_valid_c%0d", i), {31'd0, obs_valid[0]}, 32'd0);
      @(negedge clk);
    end
    for (int k = 0; k < ND; k++) begin
      check($sformatf("beat_end_valid[%0d]", k), {31'd0, obs_valid[k]}, {31'd0, last});
      check($sformatf("beat_end_ready[%0d]", k), {31'd0, obs_ready[k]}, {31'd0, ~last});
    end
  endtask

  task automatic take_result(input int hold, input string tag);
    logic [AW-1:0] e_acc [ND];
    for (int k = 0; k < ND; k++) begin
      e_acc[k] = exp_acc(k);
      check($sformatf("%s_acc[%0d]", tag, k), 32'(obs_acc[k]), 32'(e_acc[k]));
      check($sformatf("%s_ovf[%0d]", tag, k), {31'd0, obs_ovf[k]}, {31'd0, m_ovf[k]});
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
        check($sformatf("%s_hold_valid[%0d]", tag, k), {31'd0, obs_valid[k]}, 32'd1);
        check($sformatf("%s_hold_ready[%0d]", tag, k), {31'd0, obs_ready[k]}, 32'd0);
        check($sformatf("%s_hold_acc[%0d]", tag, k), 32'(obs_acc[k]), 32'(e_acc[k]));
        check($sformatf("%s_hold_ovf[%0d]", tag, k), {31'd0, obs_ovf[k]}, {31'd0, m_ovf[k]});
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < ND; k++) begin
      check($sformatf("%s_post_valid[%0d]", tag, k), {31'd0, obs_valid[k]}, 32'd0);
      check($sformatf("%s_post_ready[%0d]", tag, k), {31'd0, obs_ready[k]}, 32'd1);
      check($sformatf("%s_post_acc[%0d]", tag, k), 32'(obs_acc[k]), 32'(e_acc[k]));
    end
    model_clear();
  endtask

  initial begin
    model_clear();

    // Reset state
    rst_in = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      check($sformatf("rst_ready[%0d]", k), {31'd0, obs_ready[k]}, 32'd1);
      check($sformatf("rst_valid[%0d]", k), {31'd0, obs_valid[k]}, 32'd0);
      check($sformatf("rst_acc[%0d]", k), 32'(obs_acc[k]), 32'd0);
      check($sformatf("rst_ovf[%0d]", k), {31'd0, obs_ovf[k]}, 32'd0);
    end
    rst_in = 1'b0;
    @(negedge clk);

    // Basic single beat
    send_beat(24'h010203, 24'h040506, 1'b1);
    check("basic_const", 32'(obs_acc[0]), 32'd32);
    take_result(0, "basic");

    // Two beats forming one result
    send_beat(24'h010203, 24'h040506, 1'b0);
    send_beat(24'h010203, 24'h040506, 1'b1);
    check("multi_const", 32'(obs_acc[0]), 32'd64);
    take_result(0, "multi");

    // Unsigned overflow: saturate vs wrap
    for (int b = 0; b < 6; b++) send_beat(24'hFFFFFF, 24'hFFFFFF, b == 5);
    check("sat_const_acc", 32'(obs_acc[0]), 32'h000FFFFF);
    check("sat_const_ovf", {31'd0, obs_ovf[0]}, 32'd1);
    check("wrap_const_acc", 32'(obs_acc[1]), 32'd121874);
    check("wrap_const_ovf", {31'd0, obs_ovf[1]}, 32'd1);
    take_result(0, "sat");

    // Signed operands
    send_beat(24'hFF0201, 24'h030405, 1'b1);
    check("signed_const_a", 32'(obs_acc[2]), 32'd10);
    take_result(0, "signed_a");
    send_beat(24'hFF0000, 24'h7F0000, 1'b1);
    check("signed_const_b", 32'(obs_acc[2]), 32'h000FFF81);
    take_result(0, "signed_b");

    // Signed positive and negative overflow
    for (int b = 0; b < 12; b++) send_beat(24'h808080, 24'h808080, b == 11);
    check("spos_const", 32'(obs_acc[2]), 32'h0007FFFF);
    take_result(0, "spos");
    for (int b = 0; b < 11; b++) send_beat(24'h808080, 24'h7F7F7F, b == 10);
    check("sneg_const", 32'(obs_acc[2]), 32'h00080000);
    take_result(0, "sneg");

    // Backpressure with a stray in_valid during DONE
    send_beat(24'h112233, 24'h445566, 1'b1);
    in_valid = 1'b1;
    in_attr  = 24'hA5A5A5;
    in_coeff = 24'h5A5A5A;
    in_last  = 1'b1;
    take_result(5, "bp");
    send_beat(24'h010203, 24'h040506, 1'b1);
    check("bp_restart_const", 32'(obs_acc[0]), 32'd32);
    take_result(0, "bp_next");

    // Reset in the second MAC cycle of a non-final beat
    in_valid = 1'b1;
    in_attr  = 24'hFFFFFF;
    in_coeff = 24'hFFFFFF;
    in_last  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    model_clear();
    for (int k = 0; k < ND; k++) begin
      check($sformatf("midrst_ready[%0d]", k), {31'd0, obs_ready[k]}, 32'd1);
      check($sformatf("midrst_valid[%0d]", k), {31'd0, obs_valid[k]}, 32'd0);
      check($sformatf("midrst_acc[%0d]", k), 32'(obs_acc[k]), 32'd0);
    end
    send_beat(24'h010203, 24'h040506, 1'b1);
    check("midrst_const", 32'(obs_acc[0]), 32'd32);
    take_result(0, "midrst");

    // Random beats, random grouping and result backpressure
    for (int i = 0; i < 40; i++) begin
      logic [NE*EW-1:0] ra;
      logic [NE*EW-1:0] rc;
      logic rl;
      ra = NE*EW'($urandom);
      rc = NE*EW'($urandom);
      rl = ($urandom_range(0, 2) == 0) || (i == 39);
      send_beat(ra, rc, rl);
      if (rl) take_result(int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL global_timeout: observed no finish, expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
